// File: rtl/multi_timer_pkg.sv
// rtl/multi_timer_pkg.sv - shared register map, CTRL fields, MODE codes and FSM states for multi_timer
package multi_timer_pkg;

  // The channel field is decoded 3 bits wide, which covers up to 8 channels.
  // This lets an index at or above NUM_CH be detected and read as zero
  // instead of aliasing onto a real channel.
  localparam int CH_FIELD_W = 3;

  // Word offsets inside a channel window, taken from Addr[4:2]
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESET   = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;

  // MODE codes; 2'b10 and 2'b11 fall back to one-shot behaviour
  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // CTRL is 4 bits wide and is presented zero-extended on the bus
  function automatic logic [31:0] ctrl_word(input logic [3:0] c);
    return {28'd0, c};
  endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: registers, FSM, sticky IRQ; prescaler under MULTI_TIMER_PRESCALE_EN
module timer_channel #(
  parameter int CNT_W = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [2:0]  i_off,
  input  logic [31:0] i_din,
  output logic [31:0] o_rdata,
  output logic        o_irq
);
  import multi_timer_pkg::*;

  logic [3:0]       r_ctrl;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic             r_pending;
  timer_state_e     r_state;
  timer_state_e     w_state_next;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_wr_status;
  logic w_en;
  logic w_periodic;
  logic w_tick;
  logic w_load;
  logic w_dec;
  logic w_expire;
  logic w_en_clr;
  logic w_unused_din;

  assign w_wr_ctrl   = i_sel & i_we & (i_off == OFF_CTRL);
  assign w_wr_preset = i_sel & i_we & (i_off == OFF_PRESET);
  assign w_wr_status = i_sel & i_we & (i_off == OFF_STATUS);
  assign w_en        = r_ctrl[CTRL_EN];
  assign w_periodic  = (r_ctrl[CTRL_MODE_LSB +: 2] == MODE_PERIODIC);
  assign w_unused_din = ^i_din;

`ifdef MULTI_TIMER_PRESCALE_EN
  logic [15:0] r_prescale;
  logic [15:0] r_psc_cnt;
  logic        w_wr_prescale;

  assign w_wr_prescale = i_sel & i_we & (i_off == OFF_PRESCALE);
  assign w_tick        = (r_psc_cnt == r_prescale);

  // PRESCALE register write
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prescale <= '0;
    end else if (w_wr_prescale) begin
      r_prescale <= i_din[15:0];
    end
  end

  // Prescale counter runs only while staying in CNT; clears on tick, LOAD and on leaving CNT
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_psc_cnt <= '0;
    end else if ((r_state == ST_CNT) && (w_state_next == ST_CNT) && !w_tick) begin
      r_psc_cnt <= r_psc_cnt + 16'd1;
    end else begin
      r_psc_cnt <= '0;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // FSM next state and datapath strobes
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_expire     = 1'b0;
    w_en_clr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_load       = 1'b1;
        w_state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_state_next = ST_IDLE;
        end else if (w_tick) begin
          // PRESET of 0 behaves like 1: anything not above 1 expires now
          if (r_count > CNT_W'(1)) begin
            w_dec = 1'b1;
          end else begin
            w_expire     = 1'b1;
            w_state_next = ST_INT;
          end
        end
      end
      ST_INT: begin
        w_en_clr     = !w_periodic;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // CTRL: a CPU write beats the one-shot EN clear in the INT state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= i_din[3:0];
    end else if (w_en_clr) begin
      r_ctrl[CTRL_EN] <= 1'b0;
    end
  end

  // PRESET write; a write during CNT is picked up by the next LOAD
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_preset <= '0;
    end else if (w_wr_preset) begin
      r_preset <= i_din[CNT_W-1:0];
    end
  end

  // COUNT: load, decrement or settle at zero; frozen otherwise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= r_preset;
    end else if (w_dec) begin
      r_count <= r_count - CNT_W'(1);
    end else if (w_expire) begin
      r_count <= '0;
    end
  end

  // Sticky pending: a new expiry wins over a same-cycle clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= 1'b0;
    end else if (w_expire) begin
      r_pending <= 1'b1;
    end else if (w_wr_ctrl || (w_wr_status && i_din[0])) begin
      r_pending <= 1'b0;
    end
  end

  assign o_irq = r_pending & r_ctrl[CTRL_IM];

  // Read mux for this channel's window, no side effects
  always_comb begin
    o_rdata = '0;
    case (i_off)
      OFF_CTRL:     o_rdata = ctrl_word(r_ctrl);
      OFF_PRESET:   o_rdata = 32'(r_preset);
      OFF_COUNT:    o_rdata = 32'(r_count);
      OFF_STATUS:   o_rdata = {31'd0, r_pending};
`ifdef MULTI_TIMER_PRESCALE_EN
      OFF_PRESCALE: o_rdata = 32'(r_prescale);
`endif
      default:      o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - NUM_CH-channel down-counter timer block; optional prescaler via MULTI_TIMER_PRESCALE_EN
module multi_timer #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [NUM_CH-1:0] IRQ
);
  import multi_timer_pkg::*;

  logic [CH_FIELD_W-1:0] w_ch;
  logic [2:0]            w_off;
  logic [NUM_CH-1:0]     w_sel;
  logic [31:0]           w_rdata [NUM_CH];
  logic                  w_unused_addr;

  assign w_ch          = Addr[5 +: CH_FIELD_W];
  assign w_off         = Addr[4:2];
  assign w_unused_addr = ^{Addr[31:8], Addr[1:0]};

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_sel[gi] = (w_ch == CH_FIELD_W'(gi));

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_sel   (w_sel[gi]),
      .i_we    (WE),
      .i_off   (w_off),
      .i_din   (Din),
      .o_rdata (w_rdata[gi]),
      .o_irq   (IRQ[gi])
    );
  end

  // Read data from the selected channel; unmapped channel indices read zero
  always_comb begin
    Dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel[i]) Dout = w_rdata[i];
    end
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised successor to the fixed two-instance TC1/TC2 timer pair.
- One block holds NUM_CH independent down-counters of width CNT_W, each with a memory-mapped register window.
- Each channel has a one-shot or periodic mode and a sticky, maskable interrupt.
- Sits behind the Bridge in the memory-mapped peripheral space; its IRQ vector feeds the CPU HWInt bits.

Parameters:
- NUM_CH, 2: number of timer channels; power of two, 1 to 8.
- CNT_W, 32: counter and PRESET width, 8 to 32; registers read zero-extended to 32 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Addr  input  32  byte address. Offset = Addr[4:2]; channel = Addr[5 +: log2(NUM_CH)]; upper bits are decoded by the Bridge.
- WE  input  1  full-word write strobe, sampled at the clk rising edge.
- Din  input  32  write data.
- Dout  output  32  combinational read data for Addr.
- IRQ  output  NUM_CH  per-channel interrupt level: pending AND CTRL.IM.

Behaviour:
- Per-channel register window, stride 32 bytes:
  - 0x00 CTRL: [0] EN, [2:1] MODE, [3] IM; other bits read 0.
  - 0x04 PRESET.
  - 0x08 COUNT: read-only; writes ignored.
  - 0x0C STATUS: [0] pending; writing 1 to bit 0 clears it; writing 0 has no effect.
  - Offsets 0x10 to 0x1C and channel indices at or above NUM_CH: read 0, writes ignored.
- MODE encoding: 00 one-shot; 01 periodic; 10 and 11 behave as 00.
- Reset, asynchronous: every CTRL, PRESET, COUNT and pending bit = 0; every FSM = IDLE; IRQ = 0; Dout reflects the zeroed registers.
- Per-channel FSM, one transition per edge:
  - IDLE: if EN -> LOAD.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT:
    - if !EN -> IDLE, COUNT frozen;
    - else if COUNT > 1 -> COUNT-1, stay in CNT;
    - else COUNT <= 0, pending <= 1, -> INT.
  - INT: one-shot clears EN, -> IDLE; periodic -> IDLE, then re-LOADs.
- Latency: a CTRL write setting EN at edge E0 sets pending at edge E0 + max(PRESET,1) + 2. The periodic period is max(PRESET,1) + 3 cycles.
- PRESET = 0 is treated like 1; no wrap-around below 0.
- Pending is sticky: it stays set through later expiries and is cleared only by a STATUS write-1, a CTRL write, or reset.
- Simultaneous events:
  - A CPU write to CTRL takes priority over the FSM's INT-state EN clear.
  - A STATUS clear in the same cycle as a new expiry leaves pending = 1 (set wins).
- A PRESET write during CNT takes effect at the next LOAD only.
- Clearing EN mid-count returns to IDLE. Setting EN again restarts from LOAD with a fresh PRESET.
- Channels are fully independent; a write to one channel never alters another.
- Dout is purely combinational from Addr and the current register state, with no read side effects.

Optional Feature:
- Macro MULTI_TIMER_PRESCALE_EN.
- Defined:
  - Offset 0x10 is a per-channel 16-bit PRESCALE register, reset value 0.
  - In CNT, COUNT decrements only on every (PRESCALE+1)th cycle.
  - The prescale counter clears on LOAD and on leaving CNT.
  - Expiry latency becomes 2 + max(PRESET,1) × (PRESCALE+1) edges after the EN write.
- Undefined: offset 0x10 reads 0 and ignores writes; every CNT cycle decrements.

Decomposition:
- Shared header multi_timer_defs.v, `include-guarded and alongside constants.v, holds:
  - register offsets: CTRL, PRESET, COUNT, STATUS, PRESCALE;
  - CTRL bit positions;
  - MODE codes;
  - 2-bit FSM state encodings: IDLE, LOAD, CNT, INT.
- Sub-module timer_channel holds one channel's registers, FSM and optional prescaler. multi_timer generates NUM_CH instances and muxes Dout.

Test Plan:
- Reset mid-count: ch0 PRESET=10, EN=1; assert reset asynchronously between edges -> COUNT=0, CTRL=0, IRQ=0 immediately, with no clk edge needed.
- One-shot: ch0 PRESET=5, CTRL=0b1001 at E0 -> pending set at E7, IRQ[0]=1, EN reads 0. IRQ stays 1 until a STATUS write of 1 drops it the next cycle.
- Periodic: ch1 PRESET=3, CTRL=0b1011 -> pending set at E5. Clear it, and it sets again 6 cycles later. COUNT reads 3,2,1,0 sequence.
- Boundaries:
  - PRESET=0 one-shot expires at E3.
  - Write to COUNT is ignored.
  - Read of offset 0x14 and of channel NUM_CH returns 0.
  - Write to channel 1 leaves channel 0 untouched.
- Collision: same-cycle STATUS clear and ch0 expiry -> pending = 1. Same-cycle CTRL write and INT-state EN clear -> CTRL equals written value. Mask IM=0 -> IRQ=0 while STATUS reads 1.
- With MULTI_TIMER_PRESCALE_EN: PRESCALE=2, PRESET=4 -> pending at E14 (2 + 4×3). Without the macro, offset 0x10 reads 0.
